// File: rtl/poly_tone_pkg.sv
// Shared constants and elaboration-time helpers for the polyphonic tone generator.
package poly_tone_pkg;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_PERIOD_W = 24;
    localparam int DEF_VOL_W    = 2;
    localparam int DEF_PWM_W    = 8;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Amplitude of one volume step, sized so that every channel at full volume
    // still fits inside one PWM frame.
    function automatic int amp_step(input int pwm_w, input int num_ch, input int vol_w);
        return ((1 << pwm_w) - 1) / (num_ch * (1 << vol_w));
    endfunction

    // Width of the intermediate channel sum for the default configuration.
    localparam int MIX_W = DEF_PWM_W + clog2(DEF_NUM_CH);

endpackage

// File: rtl/poly_tone_generator_tone_channel.sv
// One square-wave oscillator: a half-period counter plus a phase flop.
// An inactive channel (disabled or zero half-period) parks at cnt = 0, phase = 0,
// so re-enabling always starts a fresh period.
module tone_channel
    import poly_tone_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] half_period,
    output logic                tone
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic                phase_q;
    logic                phase_d;

    // Next counter/phase; the >= compare lets a shrunk period wrap at once.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!enable || (half_period == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q >= (half_period - PERIOD_W'(1))) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign tone = phase_q;

endmodule

// File: rtl/poly_tone_generator.sv
// Polyphonic square-wave tone generator: NUM_CH oscillators mixed into one
// registered level, played out as a frame-synchronous PWM stream. The duty of
// each frame is latched at the frame wrap so the output never glitches mid-frame.
module poly_tone_generator
    import poly_tone_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int VOL_W    = DEF_VOL_W,
    parameter int PWM_W    = DEF_PWM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       output_enable,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic [NUM_CH*PERIOD_W-1:0] ch_half_period,
    input  logic [NUM_CH*VOL_W-1:0]    ch_volume,
    output logic [NUM_CH-1:0]          tone_out,
    output logic [PWM_W-1:0]           mix_level,
    output logic                       frame_start,
    output logic                       aud_pwm
);

    localparam int               SUM_W    = PWM_W + clog2(NUM_CH);
    localparam int               AMP_STEP = amp_step(PWM_W, NUM_CH, VOL_W);
    localparam logic [PWM_W-1:0] PWM_MAX  = {PWM_W{1'b1}};

    logic [NUM_CH-1:0] phase;
    logic [SUM_W-1:0]  amp_sum;

    logic [PWM_W-1:0]  pwm_cnt_q;
    logic [PWM_W-1:0]  pwm_cnt_d;
    logic [PWM_W-1:0]  mix_level_q;
    logic [PWM_W-1:0]  mix_level_d;
    logic [PWM_W-1:0]  duty_q;
    logic [PWM_W-1:0]  duty_d;
    logic              frame_start_q;
    logic              frame_start_d;
    logic              aud_pwm_q;
    logic              aud_pwm_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel #(
            .PERIOD_W (PERIOD_W)
        ) u_tone_channel (
            .clk         (clk),
            .rst         (rst),
            .enable      (ch_enable[i]),
            .half_period (ch_half_period[i*PERIOD_W +: PERIOD_W]),
            .tone        (phase[i])
        );
    end

    // Full-width sum of the amplitudes of every channel currently in its high phase.
    always_comb begin
        amp_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (phase[i]) begin
                amp_sum = amp_sum
                        + (SUM_W'(ch_volume[i*VOL_W +: VOL_W]) + SUM_W'(1)) * SUM_W'(AMP_STEP);
            end
        end
    end

    // Next mix level, frame counter, per-frame duty and PWM output bit.
    always_comb begin
        mix_level_d   = (amp_sum > SUM_W'(PWM_MAX)) ? PWM_MAX : amp_sum[PWM_W-1:0];
        pwm_cnt_d     = pwm_cnt_q + PWM_W'(1);
        frame_start_d = (pwm_cnt_q == PWM_MAX);
        if (!output_enable) begin
            duty_d = '0;
        end else if (pwm_cnt_q == PWM_MAX) begin
            duty_d = mix_level_q;
        end else begin
            duty_d = duty_q;
        end
        aud_pwm_d = output_enable && (pwm_cnt_q < duty_q);
    end

    // Mixer and PWM registers, all cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q     <= '0;
            mix_level_q   <= '0;
            duty_q        <= '0;
            frame_start_q <= 1'b0;
            aud_pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            mix_level_q   <= mix_level_d;
            duty_q        <= duty_d;
            frame_start_q <= frame_start_d;
            aud_pwm_q     <= aud_pwm_d;
        end
    end

    assign tone_out    = phase;
    assign mix_level   = mix_level_q;
    assign frame_start = frame_start_q;
    assign aud_pwm     = aud_pwm_q;

endmodule
